pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: memory-wait stalls, redirect flushes, CSR drain
// serialisation and load-use interlock for a five-stage in-order pipeline.
module pipe_ctrl (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [4:0]  D_rs1_i,
  input  logic [4:0]  D_rs2_i,
  input  logic        D_use_rs1_i,
  input  logic        D_use_rs2_i,
  input  logic        D_is_csr_i,
  input  logic        DD_need_dstE_i,
  input  logic [4:0]  DD_dstE_i,
  input  logic        DD_is_load_i,
  input  logic        E_redirect_i,
  input  logic        M_req_i,
  input  logic        M_ack_i,
  output logic        F_stall_o,
  output logic        F_bubble_o,
  output logic        D_stall_o,
  output logic        D_bubble_o,
  output logic        E_stall_o,
  output logic        mem_timeout_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    StIdle,
    StMemWait,
    StCsrDrain
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  drain_q, drain_d;
  logic [3:0]  wait_q, wait_d;
  logic        grant_q, grant_d;
  logic        timeout_q, timeout_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic mem_hold;
  logic f_stall, f_bubble, d_stall, d_bubble, e_stall;

  // Loads writing x0 never produce a value, so they never interlock.
  always_comb begin
    load_use = DD_is_load_i & DD_need_dstE_i & (DD_dstE_i != 5'd0) &
               ((D_use_rs1_i & (D_rs1_i == DD_dstE_i)) |
                (D_use_rs2_i & (D_rs2_i == DD_dstE_i)));
  end

  // Once waiting, only the ack releases the pipeline.
  always_comb begin
    if (state_q == StMemWait) begin
      mem_hold = ~M_ack_i;
    end else begin
      mem_hold = M_req_i & ~M_ack_i;
    end
  end

  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    wait_d    = wait_q;
    grant_d   = 1'b0;
    timeout_d = timeout_q;
    f_stall   = 1'b0;
    f_bubble  = 1'b0;
    d_stall   = 1'b0;
    d_bubble  = 1'b0;
    e_stall   = 1'b0;

    if (mem_hold) begin
      // A pending redirect is frozen in the stalled execute register.
      f_stall = 1'b1;
      d_stall = 1'b1;
      e_stall = 1'b1;
      state_d = StMemWait;
      if (state_q != StMemWait) begin
        wait_d = 4'd0;
      end else if (wait_q != 4'hF) begin
        wait_d = wait_q + 4'd1;
      end
      if ((state_q == StMemWait) && (wait_d == 4'hF)) begin
        timeout_d = 1'b1;
      end
    end else if (E_redirect_i) begin
      f_bubble = 1'b1;
      d_bubble = 1'b1;
      state_d  = StIdle;
    end else begin
      case (state_q)
        StCsrDrain: begin
          if (drain_q == 2'd0) begin
            state_d = StIdle;
            grant_d = 1'b1;
          end else begin
            f_stall = 1'b1;
            d_bubble = 1'b1;
            drain_d = drain_q - 2'd1;
          end
        end
        StIdle, StMemWait: begin
          // StMemWait here is the ack cycle; CSR entry is only taken from idle.
          state_d = StIdle;
          if ((state_q == StIdle) && D_is_csr_i && !grant_q) begin
            f_stall  = 1'b1;
            d_bubble = 1'b1;
            state_d  = StCsrDrain;
            drain_d  = 2'd2;
          end else if (load_use) begin
            f_stall  = 1'b1;
            d_bubble = 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (f_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Control outputs are combinational from inputs, so mask them during reset.
  always_comb begin
    F_stall_o     = f_stall & rst_n_i;
    F_bubble_o    = f_bubble & rst_n_i;
    D_stall_o     = d_stall & rst_n_i;
    D_bubble_o    = d_bubble & rst_n_i;
    E_stall_o     = e_stall & rst_n_i;
    mem_timeout_o = timeout_q;
    stall_cnt_o   = stall_cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      drain_q     <= 2'd0;
      wait_q      <= 4'd0;
      grant_q     <= 1'b0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      wait_q      <= wait_d;
      grant_q     <= grant_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed vector bench for pipe_ctrl: a table of single-cycle idle-state cases
// followed by hand-written multi-cycle memory-wait, CSR and reset sequences.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1, rs2, dst;
  logic        use1, use2, csr, need, load, redir, req, ack;
  logic        f_stall, f_bubble, d_stall, d_bubble, e_stall, timeout;
  logic [31:0] cnt;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_cnt = 32'd0;
  logic        exp_to = 1'b0;

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, dst;
    logic       use1, use2, load, need, csr, redir, req, ack;
    logic [4:0] exp;  // {F_stall, F_bubble, D_stall, D_bubble, E_stall}
  } vec_t;

  vec_t vecs[$];

  pipe_ctrl dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .D_rs1_i       (rs1),
    .D_rs2_i       (rs2),
    .D_use_rs1_i   (use1),
    .D_use_rs2_i   (use2),
    .D_is_csr_i    (csr),
    .DD_need_dstE_i(need),
    .DD_dstE_i     (dst),
    .DD_is_load_i  (load),
    .E_redirect_i  (redir),
    .M_req_i       (req),
    .M_ack_i       (ack),
    .F_stall_o     (f_stall),
    .F_bubble_o    (f_bubble),
    .D_stall_o     (d_stall),
    .D_bubble_o    (d_bubble),
    .E_stall_o     (e_stall),
    .mem_timeout_o (timeout),
    .stall_cnt_o   (cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    rs1 = 5'd0; rs2 = 5'd0; dst = 5'd0;
    use1 = 1'b0; use2 = 1'b0; csr = 1'b0; need = 1'b0; load = 1'b0;
    redir = 1'b0; req = 1'b0; ack = 1'b0;
  endtask

  // Inputs are already applied; check at the falling edge, then advance a cycle.
  task automatic cyc(input string name, input logic [4:0] exp);
    @(negedge clk);
    chk({name, "/ctrl"}, {27'd0, f_stall, f_bubble, d_stall, d_bubble, e_stall}, {27'd0, exp});
    chk({name, "/cnt"}, cnt, exp_cnt);
    chk({name, "/tmo"}, {31'd0, timeout}, {31'd0, exp_to});
    if (exp[4]) exp_cnt = exp_cnt + 32'd1;
    @(posedge clk);
    #1;
  endtask

  // Assert reset mid-cycle, check the asynchronous clear, release on the falling edge.
  task automatic rst_check(input string name);
    rst_n = 1'b0;
    #2;
    chk({name, "/ctrl"}, {27'd0, f_stall, f_bubble, d_stall, d_bubble, e_stall}, 32'd0);
    chk({name, "/cnt"}, cnt, 32'd0);
    chk({name, "/tmo"}, {31'd0, timeout}, 32'd0);
    set_idle();
    exp_cnt = 32'd0;
    exp_to  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string name, input logic [4:0] r1, input logic [4:0] r2,
                     input logic u1, input logic u2, input logic [4:0] d, input logic ld,
                     input logic nd, input logic c, input logic rd, input logic rq,
                     input logic ak, input logic [4:0] exp);
    vec_t v;
    v.name = name; v.rs1 = r1; v.rs2 = r2; v.use1 = u1; v.use2 = u2; v.dst = d;
    v.load = ld; v.need = nd; v.csr = c; v.redir = rd; v.req = rq; v.ack = ak;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    //   name          rs1 rs2 u1 u2 dst ld nd csr rd rq ak  exp
    add("idle",        0,  0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 5'b00000);
    add("lu_rs2_x5",   1,  5,  1, 1, 5,  1, 1, 0,  0, 0, 0, 5'b10010);
    add("lu_dst_x0",   1,  0,  1, 1, 0,  1, 1, 0,  0, 0, 0, 5'b00000);
    add("lu_rs1",      7,  3,  1, 1, 7,  1, 1, 0,  0, 0, 0, 5'b10010);
    add("rs1_unused",  7,  3,  0, 1, 7,  1, 1, 0,  0, 0, 0, 5'b00000);
    add("rs2_unused",  2,  9,  1, 0, 9,  1, 1, 0,  0, 0, 0, 5'b00000);
    add("not_load",    1,  5,  1, 1, 5,  0, 1, 0,  0, 0, 0, 5'b00000);
    add("no_wb",       1,  5,  1, 1, 5,  1, 0, 0,  0, 0, 0, 5'b00000);
    add("no_match",    4,  6,  1, 1, 5,  1, 1, 0,  0, 0, 0, 5'b00000);
    add("redirect",    0,  0,  0, 0, 0,  0, 0, 0,  1, 0, 0, 5'b01010);
    add("redir_lu",    1,  5,  1, 1, 5,  1, 1, 0,  1, 0, 0, 5'b01010);
    add("redir_csr",   0,  0,  0, 0, 0,  0, 0, 1,  1, 0, 0, 5'b01010);
    add("mem_req_ack", 0,  0,  0, 0, 0,  0, 0, 0,  0, 1, 1, 5'b00000);
    add("mem_ack_lu",  1,  5,  1, 1, 5,  1, 1, 0,  0, 1, 1, 5'b10010);
    add("ack_only",    0,  0,  0, 0, 0,  0, 0, 0,  0, 0, 1, 5'b00000);

    // Reset with hostile inputs applied: everything must read zero.
    set_idle();
    rs2 = 5'd5; use2 = 1'b1; dst = 5'd5; load = 1'b1; need = 1'b1; req = 1'b1;
    rst_check("reset");

    foreach (vecs[i]) begin
      rs1 = vecs[i].rs1; rs2 = vecs[i].rs2; use1 = vecs[i].use1; use2 = vecs[i].use2;
      dst = vecs[i].dst; load = vecs[i].load; need = vecs[i].need; csr = vecs[i].csr;
      redir = vecs[i].redir; req = vecs[i].req; ack = vecs[i].ack;
      cyc(vecs[i].name, vecs[i].exp);
    end

    // Memory wait with ack on cycle 3; redirect is held off during the wait.
    set_idle();
    req = 1'b1; redir = 1'b1;
    cyc("mw1", 5'b10101);
    cyc("mw2", 5'b10101);
    ack = 1'b1; redir = 1'b0;
    cyc("mw3_ack", 5'b00000);
    req = 1'b0; ack = 1'b0;
    cyc("mw4_idle", 5'b00000);

    // Long wait: timeout appears in the 16th cycle spent in the wait state.
    req = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      exp_to = (i >= 17);
      cyc($sformatf("tmo%0d", i), 5'b10101);
    end
    ack = 1'b1;
    cyc("tmo_ack", 5'b00000);
    req = 1'b0; ack = 1'b0;
    cyc("tmo_sticky", 5'b00000);
    rst_check("tmo_reset");
    cyc("tmo_cleared", 5'b00000);

    // CSR drain: entry plus two drain cycles, release, then one granted cycle.
    csr = 1'b1;
    cyc("csr_entry", 5'b10010);
    cyc("csr_d2", 5'b10010);
    cyc("csr_d1", 5'b10010);
    cyc("csr_rel", 5'b00000);
    cyc("csr_grant", 5'b00000);
    csr = 1'b0;
    cyc("csr_done", 5'b00000);

    // Redirect during drain flushes and returns to idle without a grant.
    csr = 1'b1;
    cyc("csr2_entry", 5'b10010);
    redir = 1'b1;
    cyc("csr2_redir", 5'b01010);
    redir = 1'b0;
    cyc("csr2_reentry", 5'b10010);
    cyc("csr2_d2", 5'b10010);
    cyc("csr2_d1", 5'b10010);
    cyc("csr2_rel", 5'b00000);
    csr = 1'b0;
    cyc("csr2_done", 5'b00000);

    // Reset in the middle of a CSR drain.
    csr = 1'b1;
    cyc("csr3_entry", 5'b10010);
    rs2 = 5'd5; use2 = 1'b1; dst = 5'd5; load = 1'b1; need = 1'b1;
    rst_check("csr3_reset");
    cyc("csr3_idle", 5'b00000);
    rs2 = 5'd5; use2 = 1'b1; dst = 5'd5; load = 1'b1; need = 1'b1;
    cyc("csr3_lu", 5'b10010);

    // Reset in the middle of a memory wait.
    set_idle();
    req = 1'b1;
    cyc("mw5_entry", 5'b10101);
    rst_check("mw5_reset");
    cyc("mw5_idle", 5'b00000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
